// File: rtl/palette_mem_ctrl.sv
// rtl/palette_mem_ctrl.sv - PPU palette RAM with backdrop mirroring, init sequencer,
// registered CPU read-back and combinational greyscale-masked render ports.
module palette_mem_ctrl #(
  parameter int                DATA_W    = 6,
  parameter int                ADDR_W    = 5,
  parameter int                NUM_RP    = 2,
  parameter int                MIRROR_EN = 1,
  parameter logic [DATA_W-1:0] INIT_VAL  = 6'h0F,
  parameter logic [DATA_W-1:0] GREY_MASK = 6'h30
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       ready,
  input  logic [ADDR_W-1:0]          addr,
  input  logic [7:0]                 data_in,
  input  logic                       WE,
  input  logic                       RE,
  output logic [7:0]                 data_out,
  output logic                       rd_valid,
  input  logic                       greyscale,
  input  logic [NUM_RP*ADDR_W-1:0]   rp_addr,
  output logic [NUM_RP*DATA_W-1:0]   rp_data
);

  localparam int ENTRIES = 2 ** ADDR_W;

  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]        r_state;
  logic [ADDR_W:0]   r_init_idx;
  logic [7:0]        r_data_out;
  logic              r_rd_valid;
  logic [DATA_W-1:0] r_mem [ENTRIES];

  logic [ADDR_W-1:0] w_cpu_eff;
  logic [DATA_W-1:0] w_wdata;
  logic              w_init_last;
  logic              w_unused_data;

  // Backdrop entries (low two bits zero) in the upper half alias onto the lower half.
  function automatic logic [ADDR_W-1:0] eff(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] r;
    r = a;
    if (MIRROR_EN != 0 && a[1:0] == 2'b00) r[ADDR_W-1] = 1'b0;
    return r;
  endfunction

  assign w_cpu_eff     = eff(addr);
  assign w_wdata       = data_in[DATA_W-1:0];
  assign w_init_last   = (r_init_idx == (ADDR_W+1)'(ENTRIES - 1));
  assign w_unused_data = &{1'b0, data_in};
  assign ready         = (r_state == S_RUN);
  assign data_out      = r_data_out;
  assign rd_valid      = r_rd_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_INIT;
      r_init_idx <= '0;
      r_data_out <= '0;
      r_rd_valid <= 1'b0;
    end else if (r_state == S_INIT) begin
      r_rd_valid <= 1'b0;
      r_init_idx <= r_init_idx + 1'b1;
      if (w_init_last) r_state <= S_RUN;
    end else begin
      r_rd_valid <= RE;
      // Single CPU address, so a simultaneous write always hits the read entry.
      if (RE) r_data_out <= 8'(WE ? w_wdata : r_mem[w_cpu_eff]);
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == S_INIT)
      r_mem[r_init_idx[ADDR_W-1:0]] <= INIT_VAL;
    else if (WE)
      r_mem[w_cpu_eff] <= w_wdata;
  end

  for (genvar g = 0; g < NUM_RP; g++) begin : g_rp
    logic [ADDR_W-1:0] w_rp_eff;
    logic [DATA_W-1:0] w_rp_raw;
    assign w_rp_eff = eff(rp_addr[g*ADDR_W +: ADDR_W]);
    assign w_rp_raw = ready ? r_mem[w_rp_eff] : INIT_VAL;
    assign rp_data[g*DATA_W +: DATA_W] = greyscale ? (w_rp_raw & GREY_MASK) : w_rp_raw;
  end

endmodule

// File: tb/tb_palette_mem_ctrl.sv
// tb/tb_palette_mem_ctrl.sv - self-checking bench for palette_mem_ctrl against a palette model.
module tb_palette_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        ready;
  logic [4:0]  addr;
  logic [7:0]  data_in;
  logic        WE;
  logic        RE;
  logic [7:0]  data_out;
  logic        rd_valid;
  logic        greyscale;
  logic [9:0]  rp_addr;
  logic [11:0] rp_data;

  int vectors = 0;
  int miscompares = 0;
  int model [32];

  palette_mem_ctrl dut (
    .clk(clk), .reset(reset), .ready(ready), .addr(addr), .data_in(data_in),
    .WE(WE), .RE(RE), .data_out(data_out), .rd_valid(rd_valid),
    .greyscale(greyscale), .rp_addr(rp_addr), .rp_data(rp_data)
  );

  always #5 clk = ~clk;

  function automatic int canon(input int a);
    if (a % 4 == 0) return a % 16;
    return a;
  endfunction

  function automatic int render_exp(input int a, input bit grey);
    int v;
    v = model[canon(a)];
    if (grey) v = v & 'h30;
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model[i] = 'h0F;
  endtask

  task automatic cpu_write(input int a, input int d);
    addr = a[4:0]; data_in = d[7:0]; WE = 1'b1;
    @(negedge clk);
    WE = 1'b0;
    model[canon(a)] = d % 64;
  endtask

  task automatic cpu_read(input int a, output int d, output bit v);
    addr = a[4:0]; RE = 1'b1;
    @(negedge clk);
    RE = 1'b0;
    d = data_out;
    v = rd_valid;
  endtask

  task automatic wait_ready(output int cycles);
    cycles = 0;
    while (!ready && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; WE = 0; RE = 0; addr = 0; data_in = 0; greyscale = 0; rp_addr = 0;
    repeat (3) @(negedge clk);
    vectors++;
    if (ready !== 1'b0 || rd_valid !== 1'b0 || data_out !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_state: ready=%b rd_valid=%b data_out=%h, want 0 0 00", ready, rd_valid, data_out);
    end
  endtask

  task automatic test_init();
    int  cycles, d;
    bit  v, saw_valid;
    WE = 1'b1; RE = 1'b1; addr = 5'h03; data_in = 8'h21; rp_addr = {5'h07, 5'h03};
    reset = 1'b0;
    cycles = 0; saw_valid = 0;
    while (!ready && cycles < 100) begin
      @(negedge clk);
      cycles++;
      if (rd_valid) saw_valid = 1;
      if (cycles == 5) begin
        vectors++;
        if (rp_data !== {6'h0F, 6'h0F}) begin
          miscompares++;
          $display("FAIL init_render: rp_data=%h, want %h", rp_data, {6'h0F, 6'h0F});
        end
      end
    end
    WE = 1'b0; RE = 1'b0;
    vectors++;
    if (cycles != 32) begin
      miscompares++;
      $display("FAIL init_latency: %0d cycles, want 32", cycles);
    end
    vectors++;
    if (saw_valid) begin
      miscompares++;
      $display("FAIL init_rd_valid: rd_valid pulsed during INIT, want none");
    end
    model_clear();
    cpu_read(3, d, v);
    vectors++;
    if (d !== 'h0F || v !== 1'b1) begin
      miscompares++;
      $display("FAIL init_write_ignored: data_out=%h rd_valid=%b, want 0f 1", d, v);
    end
    @(negedge clk);
    vectors++;
    if (rd_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rd_valid_pulse: rd_valid=%b, want 0", rd_valid);
    end
  endtask

  task automatic test_mirror();
    int d; bit v;
    cpu_write('h10, 'h2A);
    cpu_read('h00, d, v);
    vectors++;
    if (d !== 'h2A) begin
      miscompares++;
      $display("FAIL mirror_10_00: data_out=%h, want 2a", d);
    end
    rp_addr = {5'h1F, 5'h00}; greyscale = 0; #1;
    vectors++;
    if (rp_data[5:0] !== 6'h2A) begin
      miscompares++;
      $display("FAIL mirror_render: rp_data0=%h, want 2a", rp_data[5:0]);
    end
    cpu_write('h04, 'h11);
    cpu_read('h14, d, v);
    vectors++;
    if (d !== 'h11) begin
      miscompares++;
      $display("FAIL mirror_04_14: data_out=%h, want 11", d);
    end
  endtask

  task automatic test_independent();
    int d1, d2; bit v;
    cpu_write('h11, 'h16);
    cpu_write('h01, 'h27);
    cpu_read('h11, d1, v);
    cpu_read('h01, d2, v);
    vectors++;
    if (d1 !== 'h16 || d2 !== 'h27) begin
      miscompares++;
      $display("FAIL non_mirror: 11->%h 01->%h, want 16 27", d1, d2);
    end
  endtask

  task automatic test_write_first();
    int d; bit v;
    addr = 5'h08; data_in = 8'h3C; WE = 1; RE = 1;
    @(negedge clk);
    WE = 0; RE = 0;
    model[canon('h08)] = 'h3C;
    vectors++;
    if (data_out !== 8'h3C || rd_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL write_first: data_out=%h rd_valid=%b, want 3c 1", data_out, rd_valid);
    end
    cpu_write('h0B, 'hFF);
    cpu_read('h0B, d, v);
    vectors++;
    if (d !== 'h3F) begin
      miscompares++;
      $display("FAIL upper_bits: data_out=%h, want 3f", d);
    end
  endtask

  task automatic test_greyscale();
    cpu_write('h02, 'h27);
    rp_addr = {5'h0B, 5'h02};
    greyscale = 1; #1;
    vectors++;
    if (rp_data[5:0] !== 6'h20 || rp_data[11:6] !== 6'h30) begin
      miscompares++;
      $display("FAIL grey_on: rp_data=%h, want %h", rp_data, {6'h30, 6'h20});
    end
    greyscale = 0; #1;
    vectors++;
    if (rp_data[5:0] !== 6'h27 || rp_data[11:6] !== 6'h3F) begin
      miscompares++;
      $display("FAIL grey_off: rp_data=%h, want %h", rp_data, {6'h3F, 6'h27});
    end
  endtask

  task automatic test_random();
    int a, dv, d, exp, r0, r1, e0, e1;
    bit v, g;
    for (int i = 0; i < 300; i++) begin
      a = $urandom_range(0, 31);
      dv = $urandom_range(0, 255);
      case ($urandom_range(0, 2))
        0: cpu_write(a, dv);
        1: begin
          exp = model[canon(a)];
          cpu_read(a, d, v);
          vectors++;
          if (d !== exp || v !== 1'b1) begin
            miscompares++;
            $display("FAIL rand_read: addr=%h data_out=%h rd_valid=%b, want %h 1", a, d, v, exp);
          end
        end
        default: begin
          addr = a[4:0]; data_in = dv[7:0]; WE = 1; RE = 1;
          @(negedge clk);
          WE = 0; RE = 0;
          model[canon(a)] = dv % 64;
          vectors++;
          if (data_out !== 8'(dv % 64) || rd_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL rand_wr_rd: addr=%h data_out=%h, want %h", a, data_out, dv % 64);
          end
        end
      endcase
      r0 = $urandom_range(0, 31); r1 = $urandom_range(0, 31); g = 1'($urandom_range(0, 1));
      rp_addr = {r1[4:0], r0[4:0]}; greyscale = g; #1;
      e0 = render_exp(r0, g); e1 = render_exp(r1, g);
      vectors++;
      if (rp_data[5:0] !== 6'(e0) || rp_data[11:6] !== 6'(e1)) begin
        miscompares++;
        $display("FAIL rand_render: addr %h/%h grey=%b rp_data=%h, want %h", r0, r1, g, rp_data, {6'(e1), 6'(e0)});
      end
    end
    greyscale = 0;
  endtask

  task automatic test_reset_mid();
    int cycles, d, bad; bit v;
    cpu_write('h05, 'h33);
    repeat (10) @(negedge clk);
    addr = 5'h05; RE = 1;
    @(posedge clk);
    #2;
    RE = 0;
    reset = 1;
    #1;
    vectors++;
    if (ready !== 1'b0 || rd_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: ready=%b rd_valid=%b, want 0 0", ready, rd_valid);
    end
    @(negedge clk);
    reset = 0;
    wait_ready(cycles);
    vectors++;
    if (cycles != 32) begin
      miscompares++;
      $display("FAIL reinit_latency: %0d cycles, want 32", cycles);
    end
    model_clear();
    bad = 0;
    for (int a = 0; a < 32; a++) begin
      cpu_read(a, d, v);
      if (d !== model[canon(a)] || v !== 1'b1) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL reinit_clear: %0d entries not 0f, want 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_mirror();
    test_independent();
    test_write_first();
    test_greyscale();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/palette_mem_ctrl.md
Name: palette_mem_ctrl

Overview:
- Next-generation PPU palette RAM: parametrised entry count and data width.
- Full NES backdrop mirroring on both writes and reads.
- Self-clearing init sequencer after reset; registered CPU read-back port; NUM_RP asynchronous render read ports with greyscale masking.
- Sits between the PPU register interface ($2007 accesses to $3F00-$3FFF) and the pixel/VGA colour lookup.

Parameters:
- DATA_W, 6, stored colour index width (1..8).
- ADDR_W, 5, entry address width; ENTRIES = 2**ADDR_W.
- NUM_RP, 2, number of render read ports (background, sprite).
- MIRROR_EN, 1, 1 = entries with addr[1:0]==0 and addr[ADDR_W-1]==1 alias to addr[ADDR_W-1]=0.
- INIT_VAL, 6'h0F, value written to every entry by the init sequencer.
- GREY_MASK, 6'h30, AND-mask applied to render outputs when greyscale=1.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- ready  out  1  1 = init complete, CPU port accepted
- addr  in  ADDR_W  CPU access address
- data_in  in  8  CPU write data; upper 8-DATA_W bits ignored
- WE  in  1  CPU write strobe
- RE  in  1  CPU read strobe
- data_out  out  8  registered CPU read data, upper bits zero
- rd_valid  out  1  one-cycle pulse: data_out updated
- greyscale  in  1  PPUMASK bit 0
- rp_addr  in  NUM_RP*ADDR_W  packed render addresses, port i at [i*ADDR_W +: ADDR_W]
- rp_data  out  NUM_RP*DATA_W  packed render colour outputs, combinational

Behaviour:
- Address canonicalisation: eff(a) = a with top bit cleared if MIRROR_EN and a[1:0]==0; else a. Applied to CPU writes, CPU reads and render reads; storage holds one copy per canonical entry.
- FSM states:
  - INIT: entered asynchronously on reset. Counter init_idx=0, ready=0, data_out=0, rd_valid=0.
  - INIT per cycle after reset deasserts: write INIT_VAL to entry init_idx, increment. On the cycle init_idx==ENTRIES-1 is written, go to RUN.
  - RUN: ready=1. Init latency is exactly ENTRIES cycles after the first rising edge with reset low.
- In INIT, WE and RE are ignored (no write, no rd_valid). Render ports return INIT_VAL (greyscale mask still applied).
- Write (RUN, WE=1): mem[eff(addr)] <= data_in[DATA_W-1:0] at the rising edge.
- Read (RUN, RE=1): next cycle data_out = {zeros, mem[eff(addr)]}, rd_valid=1 for one cycle. data_out holds its value otherwise.
- WE and RE in the same cycle to the same effective address: write-first, data_out returns the new data. Different addresses: both proceed.
- Render ports:
  - rp_data[i] = mem[eff(rp_addr[i])], masked with GREY_MASK when greyscale=1.
  - Purely combinational; a write becomes visible the cycle after its edge.
- Reset asserted mid-operation: the FSM returns to INIT immediately, ready drops asynchronously, a pending rd_valid is cancelled, and the full clear re-runs.
- Address wrap: the init counter is ADDR_W+1 bits wide so termination is exact; no aliasing beyond ENTRIES.

Test Plan:
- Release reset, hold WE=1 addr=3 data=8'h21 throughout INIT -> ready rises after exactly 32 cycles; then RE addr=3 -> data_out=8'h0F, rd_valid one cycle (write in INIT ignored).
- RUN: write 8'h2A to addr 5'h10 -> RE addr 5'h00 returns 8'h2A; rp_addr port0=5'h00 reads 6'h2A. Write 8'h11 to 5'h04 -> RE 5'h14 returns 8'h11.
- Write 8'h16 to 5'h11 then 8'h27 to 5'h01 -> addr 5'h11 reads 8'h16, 5'h01 reads 8'h27 (non-mirrored entries independent).
- Same cycle WE+RE addr 5'h08 data 8'h3C -> next cycle data_out=8'h3C, rd_valid=1; data_in 8'hFF stored as 6'h3F, read back 8'h3F.
- Entry 5'h02=6'h27: greyscale=1 -> rp_data=6'h20; greyscale=0 -> 6'h27; both ports addressing different entries simultaneously give independent correct values.
- Assert reset 10 cycles into RUN with RE pending -> ready=0 and rd_valid=0 immediately; after release all 32 entries read 8'h0F once ready returns.
